siso_frame_rx: RTL and testbench
================================

// Module: siso_frame_rx
// PURPOSE
//  Receive end of the serial shift-register link: deframes the 1-bit stream leaving the 8-stage serial shifter
//  into parallel words with a valid/ready handshake downstream.
//  Frame = start bit (1), WIDTH data bits LSB-first, optional even-parity bit, stop bit (0).
//  The idle line is 0, matching the shifter's reset state.
// PARAMETERS
//  WIDTH      8  data bits per frame (2..32)
//  PARITY_EN  1  1: even-parity bit follows data; 0: no parity bit
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  din         in   1      serial line (shifter qout)
//  bit_en      in   1      bit strobe; din sampled only on cycles with bit_en=1
//  dout        out  WIDTH  received word, stable while valid=1
//  valid       out  1      dout holds an unconsumed word
//  ready       in   1      consumer accepts; transfer on valid&&ready
//  busy        out  1      1 in every state except IDLE
//  frame_err   out  1      1-cycle pulse: stop bit sampled as 1
//  parity_err  out  1      1-cycle pulse: parity mismatch (PARITY_EN=1 only)
//  overrun     out  1      sticky: word completed while previous word unconsumed; cleared only by rst
// BEHAVIOUR
//  - Reset: state=IDLE, bit count=0, shift reg=0. All outputs 0: dout, valid, busy, frame_err, parity_err, overrun.
//  - Synchronous rst mid-frame aborts the frame; the partial word is never delivered.
//  - FSM advances only on bit_en=1 cycles. The bit_en=0 cycles hold all state; handshake logic still runs every cycle.
//  - IDLE:   din=1 -> DATA, cnt<=0; din=0 -> stay
//  - DATA:   shreg <= {din, shreg[WIDTH-1:1]} (LSB-first); cnt++. At cnt==WIDTH-1 -> PARITY if PARITY_EN else STOP.
//  - PARITY: perr <= (^shreg ^ din); -> STOP
//  - STOP:   -> IDLE always. Outcome depends on din and perr:
//      din=1: frame_err pulse next cycle; word dropped.
//      din=0, perr=1: parity_err pulse next cycle; word dropped.
//      din=0, perr=0: word delivered (delivery rules below).
//    frame_err takes precedence over parity_err; both never pulse together.
//  - Delivery latency: dout/valid update on the cycle after the STOP bit_en cycle.
//    Frame start to valid = WIDTH+2+PARITY_EN bit strobes.
//  - Handshake:
//      valid&&ready clears valid next cycle unless a new word is delivered that same cycle.
//      Delivery with valid=0, or with valid=1&&ready=1: dout<=shreg, valid<=1 (back-to-back, no overrun).
//      Delivery with valid=1&&ready=0: new word discarded, dout unchanged, overrun<=1.
//  - ready is ignored while valid=0. dout never changes while valid=1&&ready=0.
//  - Back-to-back frames: a start bit is accepted on the first bit_en after STOP; no mandatory idle bit.
//  - busy = (state != IDLE).
//  - Widths: cnt is $clog2(WIDTH) bits; no wrap beyond WIDTH-1.
// STRUCTURE
//  - Shared package siso_pkg:
//      rx_state_t enum {IDLE, DATA, PARITY, STOP}
//      localparams START_BIT=1'b1, STOP_BIT=1'b0
//      function even_parity(). The matching transmitter uses the same package.
//  - One sub-module: siso_rx_shreg (WIDTH-bit right-shift register with enable and sync clear). The FSM, counter and
//    handshake stay in the top module.
// TESTING
//  1. rst held 3 cycles, then released -> all outputs 0, busy=0.
//     Idle line din=0 for 20 strobes -> busy stays 0, valid stays 0.
//  2. PARITY_EN=1, bit_en=1 every cycle. Send 0xA5: 1, bits 1,0,1,0,0,1,0,1, parity 0, stop 0.
//     -> valid=1 with dout=8'hA5 exactly 11 cycles after the start-bit cycle; ready=1 -> valid=0 next cycle.
//  3. Send 0x3C with parity bit 1 -> parity_err pulses exactly 1 cycle; valid stays 0.
//     Send 0x3C with stop bit 1 -> frame_err pulses 1 cycle; no parity_err.
//  4. ready=0; send 0x11 then 0x22 -> dout stays 8'h11, valid=1, overrun=1.
//     Repeat with ready=1 on the second delivery cycle -> dout=8'h22, overrun stays 0.
//  5. bit_en asserted every 3rd cycle, 0x5A -> same dout=8'h5A; timing scales to strobes.
//     Assert rst after the 4th data bit -> no valid, busy=0, next frame 0xC3 received correctly.
//  6. PARITY_EN=0, WIDTH=4: frames 0x9 and 0x6 back-to-back with no idle bit -> two deliveries, 0x9 then 0x6.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared definitions for the serial shift-register link.
// Used by both the frame receiver and the matching transmitter.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Zero-extension leaves the XOR reduction unchanged
    function automatic logic even_parity(
        input logic [31:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/siso_rx_shreg.sv
// Right-shift register that collects LSB-first serial data.
module siso_rx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional
// even parity, stop bit; delivers words over valid/ready.
module siso_frame_rx
    import siso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] sh_q;
    logic             sh_en;
    logic             fe_d, pe_d, dlv;

    siso_rx_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk (clk),
        .clr (rst),
        .en  (sh_en),
        .din (din),
        .q   (sh_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        sh_en   = 1'b0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        dlv     = 1'b0;
        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (din == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                DATA: begin
                    sh_en = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    perr_d  = even_parity(32'(sh_q)) ^ din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // A bad stop bit masks any parity outcome
                    if (din != STOP_BIT) begin
                        fe_d = 1'b1;
                    end else if (perr_q) begin
                        pe_d = 1'b1;
                    end else begin
                        dlv = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            perr_q     <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
            frame_err  <= fe_d;
            parity_err <= pe_d;
            // A word arriving while the held one is stalled is lost
            if (dlv) begin
                if (!valid || ready) begin
                    dout  <= sh_q;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_siso_frame_rx.sv
// Randomized bench for siso_frame_rx: 8-bit parity and 4-bit
// no-parity instances checked every cycle against a frame-level model.
module tb_siso_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din8 = 1'b0, en8 = 1'b0, rdy8 = 1'b0;
    logic       din4 = 1'b0, en4 = 1'b0, rdy4 = 1'b0;
    logic [7:0] dout8;
    logic [3:0] dout4;
    logic       val8, busy8, fe8, pe8, ovr8;
    logic       val4, busy4, fe4, pe4, ovr4;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = 8-bit/parity, 1 = 4-bit/no parity
    bit          mv[2];
    logic [31:0] md[2];
    bit          movr[2];
    bit          mb[2];
    bit          mfe[2];
    bit          mpe[2];
    bit          rnd_rdy = 0;
    bit          rdy_lvl = 0;

    always #5 clk = ~clk;

    siso_frame_rx #(.WIDTH(8), .PARITY_EN(1)) u8 (
        .clk(clk), .rst(rst), .din(din8), .bit_en(en8),
        .dout(dout8), .valid(val8), .ready(rdy8), .busy(busy8),
        .frame_err(fe8), .parity_err(pe8), .overrun(ovr8)
    );

    siso_frame_rx #(.WIDTH(4), .PARITY_EN(0)) u4 (
        .clk(clk), .rst(rst), .din(din4), .bit_en(en4),
        .dout(dout4), .valid(val4), .ready(rdy4), .busy(busy4),
        .frame_err(fe4), .parity_err(pe4), .overrun(ovr4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("u8.valid", 32'(val8), 32'(mv[0]));
        check("u8.dout", 32'(dout8), md[0]);
        check("u8.overrun", 32'(ovr8), 32'(movr[0]));
        check("u8.busy", 32'(busy8), 32'(mb[0]));
        check("u8.frame_err", 32'(fe8), 32'(mfe[0]));
        check("u8.parity_err", 32'(pe8), 32'(mpe[0]));
        check("u4.valid", 32'(val4), 32'(mv[1]));
        check("u4.dout", 32'(dout4), md[1]);
        check("u4.overrun", 32'(ovr4), 32'(movr[1]));
        check("u4.busy", 32'(busy4), 32'(mb[1]));
        check("u4.frame_err", 32'(fe4), 32'(mfe[1]));
        check("u4.parity_err", 32'(pe4), 32'(mpe[1]));
    endtask

    // One clock: drive sel's line, advance the model, compare.
    // dlv/fe/pe describe the frame outcome if this is a stop strobe;
    // bz is whether sel is mid-frame after this strobe.
    task automatic cyc(input int sel, input logic b, input logic e,
                       input bit dlv, input logic [31:0] w,
                       input bit fe, input bit pe, input bit frc,
                       input bit bz);
        bit r[2];
        for (int i = 0; i < 2; i++)
            r[i] = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_lvl;
        if (frc) r[sel] = 1'b1;
        din8 = (sel == 0) ? b : 1'b0;
        en8  = (sel == 0) ? e : 1'b0;
        din4 = (sel == 1) ? b : 1'b0;
        en4  = (sel == 1) ? e : 1'b0;
        rdy8 = r[0];
        rdy4 = r[1];
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mv[i] = 0; md[i] = '0; movr[i] = 0;
                mb[i] = 0; mfe[i] = 0; mpe[i] = 0;
            end else begin
                mfe[i] = (i == sel) && fe;
                mpe[i] = (i == sel) && pe;
                if (i == sel) mb[i] = bz;
                if (i == sel && dlv) begin
                    if (!mv[i] || r[i]) begin
                        mv[i] = 1; md[i] = w;
                    end else begin
                        movr[i] = 1;
                    end
                end else if (mv[i] && r[i]) begin
                    mv[i] = 0;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc(0, 1'b0, 1'b0, 0, '0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic idle(input int sel, input int n);
        repeat (n) cyc(sel, 1'b0, 1'b1, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input int sel, input logic [31:0] data,
                              input bit pflip, input logic sbit,
                              input int gap, input bit stop_rdy);
        int          w   = (sel == 0) ? 8 : 4;
        bit          pen = (sel == 0);
        logic [31:0] d   = data & ((32'd1 << w) - 1);
        logic        bits[$];
        bit          pbad, good, last;
        bits.push_back(1'b1);
        for (int k = 0; k < w; k++) bits.push_back(d[k]);
        if (pen) bits.push_back((^d) ^ pflip);
        bits.push_back(sbit);
        pbad = pen && pflip;
        good = (sbit == 1'b0) && !pbad;
        for (int j = 0; j < bits.size(); j++) begin
            last = (j == bits.size() - 1);
            cyc(sel, bits[j], 1'b1, last && good, d,
                last && sbit, last && !sbit && pbad,
                last && stop_rdy, !last);
            repeat (gap)
                cyc(sel, 1'($urandom_range(0, 1)), 1'b0,
                    0, '0, 0, 0, 0, !last);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; md[i] = '0; movr[i] = 0;
            mb[i] = 0; mfe[i] = 0; mpe[i] = 0;
        end
        do_reset(3);
        idle(0, 20);
        idle(1, 20);

        // good frame, exact latency, ready consumes
        rdy_lvl = 1;
        send_frame(0, 32'hA5, 0, 1'b0, 0, 0);
        idle(0, 2);

        // parity error, then framing error
        send_frame(0, 32'h3C, 1, 1'b0, 0, 0);
        idle(0, 2);
        send_frame(0, 32'h3C, 0, 1'b1, 0, 0);
        idle(0, 2);
        send_frame(0, 32'h3C, 1, 1'b1, 0, 0);
        idle(0, 2);

        // stalled consumer: second word lost, overrun sticks
        rdy_lvl = 0;
        send_frame(0, 32'h11, 0, 1'b0, 0, 0);
        send_frame(0, 32'h22, 0, 1'b0, 0, 0);
        idle(0, 3);
        do_reset(1);
        send_frame(0, 32'h11, 0, 1'b0, 0, 0);
        send_frame(0, 32'h22, 0, 1'b0, 0, 1);
        idle(0, 3);
        rdy_lvl = 1;
        idle(0, 2);

        // strobe every 3rd cycle, then abort mid-frame
        send_frame(0, 32'h5A, 0, 1'b0, 2, 0);
        cyc(0, 1'b1, 1'b1, 0, '0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            cyc(0, 1'($urandom_range(0, 1)), 1'b1,
                0, '0, 0, 0, 0, 1);
        do_reset(1);
        idle(0, 2);
        send_frame(0, 32'hC3, 0, 1'b0, 2, 0);
        idle(0, 2);

        // 4-bit, no parity, back-to-back
        send_frame(1, 32'h9, 0, 1'b0, 0, 0);
        send_frame(1, 32'h6, 0, 1'b0, 0, 0);
        idle(1, 3);

        // randomized traffic on both instances
        rnd_rdy = 1;
        for (int n = 0; n < 200; n++) begin
            int sel = $urandom_range(0, 1);
            send_frame(sel, $urandom,
                       ($urandom_range(0, 9) == 0),
                       1'($urandom_range(0, 9) == 0),
                       $urandom_range(0, 3), 0);
            if ($urandom_range(0, 1) == 1)
                idle(sel, $urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) do_reset(1);
        end
        idle(0, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
